// File: rtl/udp_audio_rx_player.sv
// UDP audio return path: header/sequence parser, circular jitter buffer and
// DAC playback that emits one 16-bit sample per DAC request.
module udp_audio_rx_player #(
    parameter int          ADDR_W        = 9,
    parameter int          PREFILL_WORDS = 128,
    parameter logic [15:0] MAGIC         = 16'hA55A
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              rec_en,
    input  logic [31:0]       rec_data,
    input  logic              rec_pkt_done,
    input  logic              dac_req,
    output logic [15:0]       dac_data,
    output logic              dac_vld,
    output logic              play_active,
    output logic [ADDR_W:0]   fill_words,
    output logic [15:0]       lost_pkt_cnt,
    output logic [15:0]       bad_hdr_cnt,
    output logic [15:0]       ovf_cnt,
    output logic [15:0]       udr_cnt
);

    localparam int              DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] FULL_W    = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] PREFILL_W = (ADDR_W + 1)'(PREFILL_WORDS);
    localparam logic [ADDR_W:0] FILL_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    localparam logic [1:0] P_HDR  = 2'd0;
    localparam logic [1:0] P_DATA = 2'd1;
    localparam logic [1:0] P_DROP = 2'd2;

    localparam logic [0:0] PL_PREFILL = 1'b0;
    localparam logic [0:0] PL_PLAY    = 1'b1;

    logic [1:0]        p_state;
    logic [0:0]        pl_state;
    logic              seq_known;
    logic [15:0]       exp_seq;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              half;
    logic [31:0]       out_word;
    logic [31:0]       mem [DEPTH];

    logic        hdr_ok;
    logic        push;
    logic        ovf_evt;
    logic        pop;
    logic [15:0] seq_gap;
    logic [16:0] lost_sum;
    logic [31:0] rd_word;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign hdr_ok      = (rec_data[31:16] == MAGIC);
    assign push        = rec_en && (p_state == P_DATA) && (fill_words != FULL_W);
    assign ovf_evt     = rec_en && (p_state == P_DATA) && (fill_words == FULL_W);
    assign pop         = (pl_state == PL_PLAY) && dac_req && !half && (fill_words != '0);
    assign seq_gap     = rec_data[15:0] - exp_seq;
    assign lost_sum    = {1'b0, lost_pkt_cnt} + {1'b0, seq_gap};
    assign rd_word     = mem[rd_ptr];
    assign play_active = (pl_state == PL_PLAY);

    // NOTE: the sample store has no reset; its contents are only visible through
    // fill_words, so clearing the array would add a reset fan-out with no benefit.
    always_ff @(posedge sys_clk) begin
        if (push) mem[wr_ptr] <= rec_data;
    end

    // NOTE: all state below uses non-blocking assignments so every register sees
    // pre-edge values; a later assignment in the same block (pkt_done) wins cleanly.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            p_state      <= P_HDR;
            seq_known    <= 1'b0;
            exp_seq      <= '0;
            lost_pkt_cnt <= '0;
            bad_hdr_cnt  <= '0;
            ovf_cnt      <= '0;
        end else begin
            if (rec_en) begin
                case (p_state)
                    P_HDR: begin
                        if (hdr_ok) begin
                            if (!seq_known) seq_known <= 1'b1;
                            else lost_pkt_cnt <= lost_sum[16] ? 16'hFFFF : lost_sum[15:0];
                            exp_seq <= rec_data[15:0] + 16'd1;
                            p_state <= P_DATA;
                        end else begin
                            bad_hdr_cnt <= sat_inc(bad_hdr_cnt);
                            p_state     <= P_DROP;
                        end
                    end
                    P_DATA: if (ovf_evt) ovf_cnt <= sat_inc(ovf_cnt);
                    default: ;
                endcase
            end
            if (rec_pkt_done) p_state <= P_HDR;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_words <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   fill_words <= fill_words + FILL_ONE;
                2'b01:   fill_words <= fill_words - FILL_ONE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pl_state <= PL_PREFILL;
            half     <= 1'b0;
            out_word <= '0;
            dac_data <= '0;
            dac_vld  <= 1'b0;
            udr_cnt  <= '0;
        end else begin
            dac_vld <= dac_req;
            if (pl_state == PL_PREFILL) begin
                if (dac_req) dac_data <= '0;
                if (fill_words >= PREFILL_W) begin
                    pl_state <= PL_PLAY;
                    half     <= 1'b0;
                end
            end else if (dac_req) begin
                if (half) begin
                    dac_data <= out_word[15:0];
                    half     <= 1'b0;
                end else if (pop) begin
                    out_word <= rd_word;
                    dac_data <= rd_word[31:16];
                    half     <= 1'b1;
                end else begin
                    // Underrun: mute and rebuild the prefill margin before resuming.
                    dac_data <= '0;
                    udr_cnt  <= sat_inc(udr_cnt);
                    pl_state <= PL_PREFILL;
                end
            end
        end
    end

endmodule
